// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history table (2-bit counters) plus BTB: predicts in IF, trains in EX.
// Define BHT_BYPASS_EN to forward a same-cycle EX update into the IF lookup.
module branch_predictor_bht #(
    parameter int unsigned INDEX_W  = 4,
    parameter int unsigned TAG_W    = 8,
    parameter logic [1:0]  CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
);
    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned TAG_LO  = 2 + INDEX_W;

    logic               valid_q [ENTRIES];
    logic [TAG_W-1:0]   tag_q   [ENTRIES];
    logic [1:0]         cnt_q   [ENTRIES];
    logic [29:0]        tgt_q   [ENTRIES];

    logic [INDEX_W-1:0] if_idx;
    logic [INDEX_W-1:0] ex_idx;
    logic [TAG_W-1:0]   if_tag;
    logic [TAG_W-1:0]   ex_tag;
    logic               br;
    logic               ex_hit;
    logic               wr_en;
    logic [1:0]         wr_cnt;
    logic [29:0]        wr_tgt;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [1:0]         rd_cnt;
    logic [29:0]        rd_tgt;
    logic               unused_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign if_idx = if_pc[2 +: INDEX_W];
    assign ex_idx = ex_pc[2 +: INDEX_W];
    assign if_tag = if_pc[TAG_LO +: TAG_W];
    assign ex_tag = ex_pc[TAG_LO +: TAG_W];
    assign br     = ex_valid && ex_is_branch;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Training: next contents of the EX-indexed entry.
    always_comb begin
        wr_en  = 1'b0;
        wr_cnt = cnt_q[ex_idx];
        wr_tgt = tgt_q[ex_idx];
        if (br) begin
            if (ex_hit) begin
                wr_en = 1'b1;
                if (ex_taken) begin
                    wr_cnt = sat_inc(cnt_q[ex_idx]);
                    wr_tgt = ex_target[31:2];
                end else begin
                    wr_cnt = sat_dec(cnt_q[ex_idx]);
                end
            end else if (ex_taken) begin
                // A new entry starts at CNT_INIT and immediately absorbs its first taken outcome.
                wr_en  = 1'b1;
                wr_cnt = sat_inc(CNT_INIT);
                wr_tgt = ex_target[31:2];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[ex_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[ex_idx] <= ex_tag;
            cnt_q[ex_idx] <= wr_cnt;
            tgt_q[ex_idx] <= wr_tgt;
        end
    end

    always_comb begin
        rd_valid = valid_q[if_idx];
        rd_tag   = tag_q[if_idx];
        rd_cnt   = cnt_q[if_idx];
        rd_tgt   = tgt_q[if_idx];
`ifdef BHT_BYPASS_EN
        if (wr_en && (ex_idx == if_idx)) begin
            rd_valid = 1'b1;
            rd_tag   = ex_tag;
            rd_cnt   = wr_cnt;
            rd_tgt   = wr_tgt;
        end
`endif
    end

    assign pred_taken  = rd_valid && (rd_tag == if_tag) && rd_cnt[1];
    assign pred_target = pred_taken ? {rd_tgt, 2'b00} : 32'h0;

    assign mispredict  = br && ((ex_taken != ex_pred_taken) ||
                                (ex_taken && (ex_pred_target != ex_target)));
    assign redirect_pc = mispredict ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'h0;

    assign unused_bits = ^{if_pc[1:0], if_pc[31:TAG_LO+TAG_W], ex_target[1:0]};

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomised bench for branch_predictor_bht against a table-of-integers reference model.
module tb_branch_predictor_bht;
    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    bit          m_valid [N];
    int          m_tag   [N];
    int          m_cnt   [N];
    logic [31:0] m_tgt   [N];

    always #5 clk = ~clk;

    branch_predictor_bht dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_pc          (ex_pc),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[5:2]);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'(pc[13:6]);
    endfunction

    // Entry i as it will look after the current EX resolution is absorbed.
    task automatic model_next(input int i, output bit v, output int t, output int c,
                              output logic [31:0] g);
        v = m_valid[i];
        t = m_tag[i];
        c = m_cnt[i];
        g = m_tgt[i];
        if (ex_valid && ex_is_branch && idx_of(ex_pc) == i) begin
            if (m_valid[i] && m_tag[i] == tag_of(ex_pc)) begin
                if (ex_taken) begin
                    c = (c < 3) ? c + 1 : 3;
                    g = {ex_target[31:2], 2'b00};
                end else begin
                    c = (c > 0) ? c - 1 : 0;
                end
            end else if (ex_taken) begin
                v = 1;
                t = tag_of(ex_pc);
                c = 2;
                g = {ex_target[31:2], 2'b00};
            end
        end
    endtask

    task automatic model_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i  = idx_of(pc);
        tk = m_valid[i] && m_tag[i] == tag_of(pc) && m_cnt[i] >= 2;
        tg = tk ? m_tgt[i] : 32'h0;
    endtask

    task automatic expect_pred(output logic tk, output logic [31:0] tg);
        int i;
        bit v;
        int t;
        int c;
        logic [31:0] g;
        i = idx_of(if_pc);
`ifdef BHT_BYPASS_EN
        model_next(i, v, t, c, g);
`else
        v = m_valid[i];
        t = m_tag[i];
        c = m_cnt[i];
        g = m_tgt[i];
`endif
        tk = v && t == tag_of(if_pc) && c >= 2;
        tg = tk ? g : 32'h0;
    endtask

    task automatic set_ex(input logic v, input logic b, input logic [31:0] pc, input logic t,
                          input logic [31:0] tg, input logic pt, input logic [31:0] ptg);
        ex_valid       = v;
        ex_is_branch   = b;
        ex_pc          = pc;
        ex_taken       = t;
        ex_target      = tg;
        ex_pred_taken  = pt;
        ex_pred_target = ptg;
    endtask

    // Check all outputs against the model, then clock once and commit the model update.
    task automatic cycle(input string tag);
        logic        et;
        logic [31:0] eg;
        logic        emp;
        logic [31:0] erd;
        bit          nv;
        int          nt;
        int          nc;
        logic [31:0] ng;
        int          ei;
        bit          br;
        #1;
        if (!rst_n) begin
            foreach (m_valid[i]) m_valid[i] = 0;
        end
        br = ex_valid && ex_is_branch;
        expect_pred(et, eg);
        emp = br && ((ex_taken != ex_pred_taken) || (ex_taken && ex_pred_target != ex_target));
        erd = emp ? (ex_taken ? ex_target : ex_pc + 32'd4) : 32'h0;
        check_eq({tag, ".pred_taken"}, pred_taken, et);
        check_eq({tag, ".pred_target"}, pred_target, eg);
        check_eq({tag, ".mispredict"}, mispredict, emp);
        check_eq({tag, ".redirect_pc"}, redirect_pc, erd);
        ei = idx_of(ex_pc);
        model_next(ei, nv, nt, nc, ng);
        @(posedge clk);
        if (rst_n) begin
            m_valid[ei] = nv;
            m_tag[ei]   = nt;
            m_cnt[ei]   = nc;
            m_tgt[ei]   = ng;
        end
        #1;
    endtask

    task automatic idle();
        set_ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = 32'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2));
        if ($urandom_range(0, 7) == 0) p[12] = 1'b1;
        if ($urandom_range(0, 7) == 0) p[14] = 1'b1;
        return p;
    endfunction

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        idle();
        @(posedge clk);
        #1;
        check_eq("reset.pred_taken", pred_taken, 32'd0);
        check_eq("reset.pred_target", pred_target, 32'd0);
        cycle("reset");
        rst_n = 1'b1;

        // First taken resolution allocates at weakly taken.
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
        check_eq("alloc.mispredict", mispredict, 32'd1);
        check_eq("alloc.redirect_pc", redirect_pc, 32'h80);
        cycle("alloc");
        idle();
        #1;
        check_eq("hit.pred_taken", pred_taken, 32'd1);
        check_eq("hit.pred_target", pred_target, 32'h80);
        cycle("hit");

        repeat (3) begin
            set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
            cycle("train_taken");
        end
        set_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        check_eq("nt1.redirect_pc", redirect_pc, 32'h104);
        cycle("nt1");
        idle();
        #1;
        check_eq("sat_then_nt1.pred_taken", pred_taken, 32'd1);
        cycle("after_nt1");
        set_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        check_eq("nt2.mispredict", mispredict, 32'd1);
        check_eq("nt2.redirect_pc", redirect_pc, 32'h104);
        cycle("nt2");
        idle();
        #1;
        check_eq("after_nt2.pred_taken", pred_taken, 32'd0);
        cycle("after_nt2");

        // Same index, different tag overwrites the occupant.
        set_ex(1'b1, 1'b1, 32'h1100, 1'b1, 32'h200, 1'b0, 32'h0);
        cycle("alias_alloc");
        idle();
        #1;
        check_eq("alias_old.pred_taken", pred_taken, 32'd0);
        cycle("alias_old");
        if_pc = 32'h1100;
        #1;
        check_eq("alias_new.pred_target", pred_target, 32'h200);
        cycle("alias_new");

        // Bring 0x100 to a hit at cnt=01, then read and train the same index together.
        if_pc = 32'h100;
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        cycle("realloc");
        set_ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        cycle("to_wnt");
        set_ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        #1;
`ifdef BHT_BYPASS_EN
        check_eq("same_cycle.pred_taken", pred_taken, 32'd1);
`else
        check_eq("same_cycle.pred_taken", pred_taken, 32'd0);
`endif
        cycle("same_cycle");

        // Unqualified branch: no mispredict and no training.
        set_ex(1'b0, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
        #1;
        check_eq("novalid.mispredict", mispredict, 32'd0);
        cycle("novalid");
        idle();
        #1;
        check_eq("novalid_after.pred_taken", pred_taken, 32'd1);
        cycle("novalid_after");

        // Asynchronous reset between edges, with an update pending on the next edge.
        set_ex(1'b1, 1'b1, 32'h300, 1'b1, 32'h40, 1'b0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid.pred_taken", pred_taken, 32'd0);
        cycle("rst_mid");
        rst_n = 1'b1;
        idle();
        #1;
        check_eq("post_rst_100.pred_taken", pred_taken, 32'd0);
        cycle("post_rst_100");
        if_pc = 32'h300;
        #1;
        check_eq("post_rst_300.pred_taken", pred_taken, 32'd0);
        cycle("post_rst_300");

        for (int n = 0; n < 800; n++) begin
            logic [31:0] p;
            logic        pt;
            logic [31:0] ptg;
            p = rand_pc();
            if_pc = ($urandom_range(0, 3) == 0) ? p : rand_pc();
            model_lookup(p, pt, ptg);
            if ($urandom_range(0, 3) == 0) begin
                pt  = 1'($urandom_range(0, 1));
                ptg = $urandom & 32'h0000_03fc;
            end
            set_ex(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) != 0), p,
                   1'($urandom_range(0, 1)), $urandom & 32'h0000_03ff, pt, ptg);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle("rand");
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
